// File: rtl/battleship_pkg.sv
// Shared types and defaults for the PC-side battleship board.
// State encoding, board defaults and the ship-count clamp helper.
package battleship_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLACE,
    READY,
    RESP,
    SUNK
  } state_t;

  localparam int BOARD_N_DEFAULT    = 5;
  localparam int SHIP_LIMIT_DEFAULT = 5;

  function automatic logic [2:0] clamp_ships(
    input logic [2:0] req,
    input logic [2:0] lim
  );
    logic [2:0] r;
    r = req;
    if (req == 3'd0) r = 3'd1;
    else if (req > lim) r = lim;
    return r;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Loads the seed while reset is held low.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (!rst) q <= seed;
    else      q <= {q[6:0], fb};
  end

endmodule

// File: rtl/pc_board_responder.sv
// PC battleship board: random ship placement and shot responder.
// Board is held in flat ship/shot bit vectors indexed i*BOARD_N+j.
module pc_board_responder
  import battleship_pkg::*;
#(
  parameter int         BOARD_N    = BOARD_N_DEFAULT,
  parameter int         SHIP_LIMIT = SHIP_LIMIT_DEFAULT,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       place_start,
  input  logic [2:0] amount_of_ships,
  input  logic       shot_valid,
  input  logic [2:0] shot_i,
  input  logic [2:0] shot_j,
  output logic       shot_ready,
  output logic       resp_valid,
  output logic       resp_hit,
  output logic       resp_repeat,
  output logic [2:0] pc_ships,
  output logic       placing_done,
  output logic       all_sunk,
  input  logic [2:0] rd_i,
  input  logic [2:0] rd_j,
  output logic       rd_ship,
  output logic       rd_shot
);

  localparam int         CELLS = BOARD_N * BOARD_N;
  localparam int         IW    = $clog2(CELLS);
  localparam logic [3:0] N4    = 4'(BOARD_N);
  localparam logic [2:0] LIM   = 3'(SHIP_LIMIT);

  state_t             state_q, state_d;
  logic [CELLS-1:0]   ship_q, ship_d;
  logic [CELLS-1:0]   shot_q, shot_d;
  logic [2:0]         ships_q, ships_d;
  logic [2:0]         target_q, target_d;
  logic               done_q, done_d;
  logic [2:0]         si_q, si_d, sj_q, sj_d;
  logic               rd_ship_q, rd_shot_q;
  logic [7:0]         lfsr_q;
  logic               lfsr_unused;

  logic               cand_ok, shot_ok, rd_ok, shot_hit;
  logic [IW-1:0]      cand_idx, shot_idx, rd_idx;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[7:6];

  assign cand_ok  = ({1'b0, lfsr_q[2:0]} < N4)
                 && ({1'b0, lfsr_q[5:3]} < N4);
  assign cand_idx = IW'(int'(lfsr_q[2:0]) * BOARD_N
                 + int'(lfsr_q[5:3]));
  assign shot_ok  = ({1'b0, si_q} < N4) && ({1'b0, sj_q} < N4);
  assign shot_idx = IW'(int'(si_q) * BOARD_N + int'(sj_q));
  assign rd_ok    = ({1'b0, rd_i} < N4) && ({1'b0, rd_j} < N4);
  assign rd_idx   = IW'(int'(rd_i) * BOARD_N + int'(rd_j));
  assign shot_hit = shot_ok && ship_q[shot_idx] && !shot_q[shot_idx];

  always_comb begin
    state_d     = state_q;
    ship_d      = ship_q;
    shot_d      = shot_q;
    ships_d     = ships_q;
    target_d    = target_q;
    done_d      = done_q;
    si_d        = si_q;
    sj_d        = sj_q;
    resp_valid  = 1'b0;
    resp_hit    = 1'b0;
    resp_repeat = 1'b0;
    // A restart outranks everything, including a response in flight
    if (place_start && state_q != PLACE) begin
      ship_d   = '0;
      shot_d   = '0;
      target_d = clamp_ships(amount_of_ships, LIM);
      ships_d  = 3'd0;
      done_d   = 1'b0;
      state_d  = PLACE;
    end else begin
      unique case (state_q)
        IDLE: ;
        PLACE: begin
          if (ships_q == target_q) begin
            done_d  = 1'b1;
            state_d = READY;
          end else if (cand_ok && !ship_q[cand_idx]) begin
            ship_d[cand_idx] = 1'b1;
            ships_d          = ships_q + 3'd1;
          end
        end
        READY: begin
          if (shot_valid) begin
            si_d    = shot_i;
            sj_d    = shot_j;
            state_d = RESP;
          end
        end
        RESP: begin
          resp_valid  = 1'b1;
          resp_hit    = shot_hit;
          resp_repeat = !shot_ok || shot_q[shot_idx];
          if (shot_ok) shot_d[shot_idx] = 1'b1;
          if (shot_hit && ships_q != 3'd0) ships_d = ships_q - 3'd1;
          state_d = (ships_d == 3'd0) ? SUNK : READY;
        end
        SUNK: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ship_q    <= '0;
      shot_q    <= '0;
      ships_q   <= 3'd0;
      target_q  <= 3'd0;
      done_q    <= 1'b0;
      si_q      <= 3'd0;
      sj_q      <= 3'd0;
      rd_ship_q <= 1'b0;
      rd_shot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ship_q    <= ship_d;
      shot_q    <= shot_d;
      ships_q   <= ships_d;
      target_q  <= target_d;
      done_q    <= done_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      rd_ship_q <= rd_ok && ship_q[rd_idx];
      rd_shot_q <= rd_ok && shot_q[rd_idx];
    end
  end

  assign shot_ready   = (state_q == READY);
  assign all_sunk     = (state_q == SUNK);
  assign pc_ships     = ships_q;
  assign placing_done = done_q;
  assign rd_ship      = rd_ship_q;
  assign rd_shot      = rd_shot_q;

endmodule

// File: tb/tb_pc_board_responder.sv
// Randomized bench for pc_board_responder against a game-level model.
// Directed scenarios pin the model with hand-computed values.
module tb_pc_board_responder;

  localparam int         N    = 5;
  localparam int         LIM  = 5;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       place_start = 1'b0;
  logic [2:0] amount_of_ships = 3'd0;
  logic       shot_valid = 1'b0;
  logic [2:0] shot_i = 3'd0, shot_j = 3'd0;
  logic [2:0] rd_i = 3'd0, rd_j = 3'd0;
  logic       shot_ready, resp_valid, resp_hit, resp_repeat;
  logic [2:0] pc_ships;
  logic       placing_done, all_sunk, rd_ship, rd_shot;

  int checks = 0;
  int errors = 0;

  pc_board_responder #(
    .BOARD_N(N), .SHIP_LIMIT(LIM), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .place_start(place_start),
    .amount_of_ships(amount_of_ships), .shot_valid(shot_valid),
    .shot_i(shot_i), .shot_j(shot_j), .shot_ready(shot_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_repeat(resp_repeat), .pc_ships(pc_ships),
    .placing_done(placing_done), .all_sunk(all_sunk),
    .rd_i(rd_i), .rd_j(rd_j), .rd_ship(rd_ship), .rd_shot(rd_shot)
  );

  always #5 clk = ~clk;

  // game-level model
  bit         m_ship[8][8];
  bit         m_shot[8][8];
  int         m_ships, m_target;
  bit         m_done, m_placing, m_ready, m_pending, m_sunk;
  int         m_pi, m_pj;
  logic [7:0] m_lfsr;
  bit         m_rds, m_rdh;
  bit         started = 0;

  function automatic bit in_rng(int i, int j);
    return i < N && j < N;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    started <= 1;
    if (!rst) begin
      foreach (m_ship[a, b]) begin
        m_ship[a][b] = 0;
        m_shot[a][b] = 0;
      end
      m_ships = 0; m_target = 0; m_done = 0;
      m_placing = 0; m_ready = 0; m_pending = 0; m_sunk = 0;
      m_lfsr = SEED; m_rds = 0; m_rdh = 0;
    end else begin
      m_rds = in_rng(rd_i, rd_j) && m_ship[rd_i][rd_j];
      m_rdh = in_rng(rd_i, rd_j) && m_shot[rd_i][rd_j];
      if (place_start && !m_placing) begin
        foreach (m_ship[a, b]) begin
          m_ship[a][b] = 0;
          m_shot[a][b] = 0;
        end
        m_target = amount_of_ships == 0 ? 1 :
                   (amount_of_ships > LIM ? LIM : amount_of_ships);
        m_ships = 0; m_done = 0; m_placing = 1;
        m_ready = 0; m_pending = 0; m_sunk = 0;
      end else if (m_placing) begin
        if (m_ships == m_target) begin
          m_placing = 0; m_ready = 1; m_done = 1;
        end else if (in_rng(m_lfsr[2:0], m_lfsr[5:3]) &&
                     !m_ship[m_lfsr[2:0]][m_lfsr[5:3]]) begin
          m_ship[m_lfsr[2:0]][m_lfsr[5:3]] = 1;
          m_ships++;
        end
      end else if (m_ready) begin
        if (shot_valid) begin
          m_pi = shot_i; m_pj = shot_j;
          m_ready = 0; m_pending = 1;
        end
      end else if (m_pending) begin
        m_pending = 0;
        if (in_rng(m_pi, m_pj)) begin
          if (m_ship[m_pi][m_pj] && !m_shot[m_pi][m_pj] && m_ships > 0)
            m_ships--;
          m_shot[m_pi][m_pj] = 1;
        end
        if (m_ships == 0) m_sunk = 1;
        else m_ready = 1;
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // per-cycle compare, mid-cycle while inputs are stable
  always @(negedge clk) begin
    bit ev, eh, er;
    if (started) begin
      ev = m_pending && !place_start;
      eh = ev && in_rng(m_pi, m_pj) && m_ship[m_pi][m_pj]
              && !m_shot[m_pi][m_pj];
      er = ev && (!in_rng(m_pi, m_pj) || m_shot[m_pi][m_pj]);
      check("shot_ready", shot_ready, m_ready);
      check("resp_valid", resp_valid, ev);
      check("resp_hit", resp_hit, eh);
      check("resp_repeat", resp_repeat, er);
      check("pc_ships", pc_ships, m_ships);
      check("placing_done", placing_done, m_done);
      check("all_sunk", all_sunk, m_sunk);
      check("rd_ship", rd_ship, m_rds);
      check("rd_shot", rd_shot, m_rdh);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(int amt);
    amount_of_ships = 3'(amt);
    place_start = 1;
    tick();
    place_start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!placing_done && n < 260) begin
      tick();
      n++;
    end
    check("place_within_bound", placing_done, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!shot_ready && n < 10) begin
      tick();
      n++;
    end
    check("ready_within_bound", shot_ready, 1);
  endtask

  task automatic scan(output int nship, output int nshot);
    nship = 0;
    nshot = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        rd_i = 3'(i);
        rd_j = 3'(j);
        tick();
        nship += int'(rd_ship);
        nshot += int'(rd_shot);
      end
  endtask

  task automatic shoot(int i, int j);
    shot_i = 3'(i);
    shot_j = 3'(j);
    shot_valid = 1;
    tick();
    shot_valid = 0;
  endtask

  initial begin
    int ns, nh, ci, cj, n;
    // reset
    rst = 0;
    tick(); tick();
    check("rst_ready", shot_ready, 0);
    check("rst_ships", pc_ships, 0);
    check("rst_done", placing_done, 0);
    check("rst_resp", resp_valid, 0);
    rst = 1;
    repeat (4) tick();
    check("idle_ready", shot_ready, 0);
    check("idle_done", placing_done, 0);

    // placement clamped to the ship limit
    start_game(7);
    wait_done();
    check("place_ships_5", pc_ships, 5);
    scan(ns, nh);
    check("scan_ships_5", ns, 5);
    check("scan_shots_0", nh, 0);

    // hit, then repeat on the same cell
    ci = -1; cj = -1;
    foreach (m_ship[a, b])
      if (ci < 0 && m_ship[a][b]) begin
        ci = a;
        cj = b;
      end
    wait_ready();
    shoot(ci, cj);
    tick();
    check("ships_after_hit", pc_ships, 4);
    wait_ready();
    shot_i = 3'(ci); shot_j = 3'(cj); shot_valid = 1;
    tick();
    check("repeat_valid", resp_valid, 1);
    check("repeat_hit", resp_hit, 0);
    check("repeat_rep", resp_repeat, 1);
    shot_valid = 0;
    tick();
    check("ships_after_repeat", pc_ships, 4);

    // out of range, shot_valid held through the response cycle
    wait_ready();
    shot_i = 3'd7; shot_j = 3'd2; shot_valid = 1;
    tick();
    check("oor_valid", resp_valid, 1);
    check("oor_rep", resp_repeat, 1);
    tick();
    shot_valid = 0;
    check("oor_no_second", resp_valid, 0);
    check("oor_ships", pc_ships, 4);

    // sink the rest
    foreach (m_ship[a, b])
      if (m_ship[a][b] && !m_shot[a][b] && !m_sunk) begin
        wait_ready();
        shoot(a, b);
        tick();
      end
    check("sunk_flag", all_sunk, 1);
    check("sunk_ready", shot_ready, 0);

    // zero request clamps to one ship
    start_game(0);
    wait_done();
    check("one_ship", pc_ships, 1);
    scan(ns, nh);
    check("one_ship_scan", ns, 1);
    check("cleared_shots", nh, 0);

    // randomized play with occasional restarts
    for (int c = 0; c < 3000; c++) begin
      place_start = ($urandom_range(0, 59) == 0) || m_sunk;
      amount_of_ships = 3'($urandom);
      shot_valid = 1'($urandom);
      shot_i = ($urandom_range(0, 9) == 0) ? 3'($urandom)
                                           : 3'($urandom_range(0, N-1));
      shot_j = ($urandom_range(0, 9) == 0) ? 3'($urandom)
                                           : 3'($urandom_range(0, N-1));
      rd_i = 3'($urandom);
      rd_j = 3'($urandom);
      tick();
    end
    place_start = 0;
    shot_valid = 0;

    // reset while a response is showing
    start_game(3);
    wait_done();
    wait_ready();
    shot_i = 3'd0; shot_j = 3'd0; shot_valid = 1;
    tick();
    check("pre_rst_valid", resp_valid, 1);
    shot_valid = 0;
    rst = 0;
    tick();
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_ships", pc_ships, 0);
    check("rst_resp_ready", shot_ready, 0);
    rst = 1;
    n = 0;
    repeat (3) begin
      tick();
      n += int'(shot_ready) + int'(placing_done);
    end
    check("idle_after_rst", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_board_responder.md
PC_BOARD_RESPONDER -- requirements
Module: pc_board_responder

Interface
REQ-001 SHALL have parameter BOARD_N, default 5, meaning rows/cols of the PC board (indices 0..BOARD_N-1).
REQ-002 SHALL have parameter SHIP_LIMIT, default 5, meaning the maximum PC ship count.
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, meaning the nonzero LFSR reset value.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 Ports, in order:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- place_start  in  1  one-cycle pulse that starts PC ship placement.
- amount_of_ships  in  3  requested ship count.
- shot_valid  in  1  player shot request.
- shot_i, shot_j  in  3 each  shot row/col.
- shot_ready  out  1  responder can accept a shot.
- resp_valid  out  1  response strobe, one cycle.
- resp_hit  out  1  new hit on a ship.
- resp_repeat  out  1  cell already shot, or coordinates out of range.
- pc_ships  out  3  ships remaining.
- placing_done  out  1  placement complete.
- all_sunk  out  1  PC defeated.
- rd_i, rd_j  in  3 each  display read address.
- rd_ship, rd_shot  out  1 each  display read data, registered.

Function
REQ-006 States SHALL be: IDLE, PLACE, READY, RESP, SUNK.
REQ-007 The 8-bit maximal-length LFSR (taps x^8+x^6+x^5+x^4+1) SHALL advance every cycle in every state.
REQ-008 place_start, in any state except PLACE, SHALL:
- clear all ship and shot bits;
- load the target = clamp(amount_of_ships, 1, SHIP_LIMIT);
- set pc_ships=0 and placing_done=0;
- enter PLACE.
REQ-009 PLACE, each cycle: candidate i=lfsr[2:0], j=lfsr[5:3]; if both are < BOARD_N and the cell is empty, set the ship bit and increment pc_ships.
REQ-010 PLACE SHALL go to READY with placing_done=1 in the cycle after pc_ships reaches the target; placement SHALL complete within 256 cycles of place_start.
REQ-011 shot_ready SHALL be 1 only in READY.
REQ-012 A shot SHALL be accepted on shot_valid && shot_ready; coordinates are captured and the state goes to RESP.
REQ-013 In RESP (exactly the cycle after acceptance), resp_valid=1 for one cycle with:
- resp_hit = ship && !shot;
- resp_repeat = already shot, or out of range.
REQ-014 In that same RESP cycle, for an in-range cell:
- set the shot bit;
- on a new hit, decrement pc_ships.
REQ-015 Out-of-range shots SHALL change no board state and give resp_hit=0, resp_repeat=1.
REQ-016 After RESP:
- if pc_ships==0, go to SUNK with all_sunk=1 and shot_ready=0;
- otherwise return to READY.
REQ-017 pc_ships SHALL never wrap below 0.
REQ-018 shot_valid outside READY SHALL be ignored and not queued.
REQ-019 rd_ship/rd_shot SHALL be registered with 1-cycle latency and read 0 for out-of-range addresses.
REQ-020 place_start arriving in READY, RESP or SUNK SHALL abort the game and restart placement; any pending response is dropped.

Reset
REQ-021 While rst=0 at a clk edge, the following SHALL be forced:
- state=IDLE;
- board cleared;
- LFSR=LFSR_SEED;
- pc_ships=0, target=0;
- all outputs 0.
REQ-022 Reset SHALL take priority over place_start and shot handshakes.

Structure
REQ-023 Package battleship_pkg SHALL hold the state enum, BOARD_N_DEFAULT and SHIP_LIMIT_DEFAULT.
REQ-024 The LFSR SHALL be a separate sub-module, lfsr8 (clk, rst, seed, q).
REQ-025 The board SHALL be flat registers (BOARD_N*BOARD_N ship bits plus shot bits); no RAM inference.

Verification
REQ-026 Reset: rst=0 for 2 cycles -> all outputs 0, shot_ready=0; rst=1 with no stimulus -> state remains IDLE.
REQ-027 amount_of_ships=7, place_start -> placing_done=1 within 256 cycles, pc_ships=5, rd scan finds exactly 5 ship cells.
REQ-028 Shot a ship cell found by rd scan -> next cycle resp_valid=1, resp_hit=1, pc_ships 5->4; same cell again -> resp_hit=0, resp_repeat=1, pc_ships stays 4.
REQ-029 Shot (7,2) -> resp_valid=1, resp_hit=0, resp_repeat=1, board and pc_ships unchanged; shot_valid held during RESP -> no second response.
REQ-030 Sink all ships -> all_sunk=1, shot_ready=0; then place_start with amount_of_ships=0 -> board cleared, pc_ships=1 after placement.
REQ-031 rst=0 asserted during RESP -> next cycle resp_valid=0, pc_ships=0, state IDLE.
